// File: rtl/bridge_cmd_engine_if.sv
// Bridge, forwarded host-command and target-queue signal bundle for bridge_cmd_engine.
// master = bridge/core side driving the engine, slave = the engine itself.
interface bridge_cmd_engine_if;
  logic        bridge_endian_little;
  logic [31:0] bridge_addr;
  logic        bridge_rd;
  logic [31:0] bridge_rd_data;
  logic        bridge_wr;
  logic [31:0] bridge_wr_data;
  logic        status_boot_done;
  logic        status_setup_done;
  logic        status_running;
  logic        core_reset_n;
  logic        osnotify_inmenu;
  logic        hcmd_valid;
  logic        hcmd_ready;
  logic [15:0] hcmd_id;
  logic [31:0] hcmd_param;
  logic        hcmd_rsp_valid;
  logic [15:0] hcmd_rsp_code;
  logic        tq_wr;
  logic [15:0] tq_cmd;
  logic [31:0] tq_param;
  logic        tq_full;
  logic        tq_done;
  logic [15:0] tq_result;

  modport master (
    output bridge_endian_little, bridge_addr, bridge_rd, bridge_wr, bridge_wr_data,
           status_boot_done, status_setup_done, status_running,
           hcmd_ready, hcmd_rsp_valid, hcmd_rsp_code, tq_wr, tq_cmd, tq_param,
    input  bridge_rd_data, core_reset_n, osnotify_inmenu, hcmd_valid, hcmd_id,
           hcmd_param, tq_full, tq_done, tq_result
  );

  modport slave (
    input  bridge_endian_little, bridge_addr, bridge_rd, bridge_wr, bridge_wr_data,
           status_boot_done, status_setup_done, status_running,
           hcmd_ready, hcmd_rsp_valid, hcmd_rsp_code, tq_wr, tq_cmd, tq_param,
    output bridge_rd_data, core_reset_n, osnotify_inmenu, hcmd_valid, hcmd_id,
           hcmd_param, tq_full, tq_done, tq_result
  );
endinterface

// File: rtl/bridge_cmd_engine.sv
// Host/target command engine on the 0xF8xxxxxx bridge window.
// Optional forwarded-command timeout: define BRIDGE_CMD_TIMEOUT_EN.
//
// host FSM   | meaning
// H_IDLE     | waiting for 0x434D command write to host_0
// H_PARSE    | host_0 = 0x4255 busy, run built-in or forward
// H_EXT      | forwarded to core, waiting handshake + result
// H_DONE     | host_0 = 0x4F4B + result code
// target FSM | meaning
// T_IDLE     | waiting for internal request or queued command
// T_ISSUE    | publish command into target_0 / target_20
// T_WAIT     | waiting for host to write 0x6F6B ack into target_0
module bridge_cmd_engine #(
  parameter int NPARAM         = 4,
  parameter int TQ_DEPTH       = 4,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input logic               clk,
  input logic               reset_n,
  bridge_cmd_engine_if.slave bus
);
  localparam int AW = $clog2(TQ_DEPTH);

  typedef enum logic [1:0] {H_IDLE, H_PARSE, H_EXT, H_DONE} h_state_t;
  typedef enum logic [1:0] {T_IDLE, T_ISSUE, T_WAIT} t_state_t;

  function automatic logic [31:0] swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  h_state_t    r_hstate;
  t_state_t    r_tstate;
  logic [31:0] r_host0, r_host4, r_host8, r_tgt0, r_tgt4, r_tgt8;
  logic [31:0] r_host_par [NPARAM];
  logic [31:0] r_host_rsp [NPARAM];
  logic [31:0] r_tgt_par  [NPARAM];
  logic [31:0] r_tgt_rsp  [NPARAM];
  logic [31:0] r_rd_data;
  logic [15:0] r_cmd, r_code;
  logic        r_accepted, r_core_reset_n, r_osnotify;
  logic        r_hcmd_valid;
  logic [15:0] r_hcmd_id;
  logic [31:0] r_hcmd_param;
  logic [15:0] r_fq_cmd [TQ_DEPTH];
  logic [31:0] r_fq_par [TQ_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic        r_setup_q, r_setup_pend;
  logic [15:0] r_tcmd;
  logic [31:0] r_tpar;
  logic        r_tq_done;
  logic [15:0] r_tq_result;

  logic [31:0] w_wdata, w_rdata;
  logic        w_win, w_host, w_tgt, w_par_sel, w_rsp_sel;
  logic [7:0]  w_off;
  logic [2:0]  w_idx;
  logic [2:0]  w_status_code;
  logic        w_full, w_push, w_pop, w_int_req, w_setup_rise, w_rsp_ok;

  assign w_wdata   = bus.bridge_endian_little ? swap32(bus.bridge_wr_data) : bus.bridge_wr_data;
  assign w_win     = (bus.bridge_addr[31:24] == 8'hF8) && (bus.bridge_addr[1:0] == 2'b00);
  assign w_host    = w_win && (bus.bridge_addr[15:8] == 8'h00);
  assign w_tgt     = w_win && (bus.bridge_addr[15:8] == 8'h10);
  assign w_off     = bus.bridge_addr[7:0];
  assign w_idx     = bus.bridge_addr[4:2];
  assign w_par_sel = (bus.bridge_addr[7:5] == 3'b001);
  assign w_rsp_sel = (bus.bridge_addr[7:5] == 3'b010);

  assign w_status_code = bus.status_running    ? 3'd4 :
                         bus.status_setup_done ? 3'd3 :
                         bus.status_boot_done  ? 3'd2 : 3'd1;

  assign w_full       = (r_count == (AW+1)'(TQ_DEPTH));
  assign w_push       = bus.tq_wr && !w_full;
  assign w_setup_rise = bus.status_setup_done && !r_setup_q;
  assign w_int_req    = r_setup_pend || w_setup_rise;
  assign w_pop        = (r_tstate == T_IDLE) && !w_int_req && (r_count != '0);
  // a response arriving together with the handshake counts as accepted
  assign w_rsp_ok     = bus.hcmd_rsp_valid && (r_accepted || (r_hcmd_valid && bus.hcmd_ready));

  always_comb begin
    w_rdata = '0;
    if (w_host) begin
      case (w_off)
        8'h00:   w_rdata = r_host0;
        8'h04:   w_rdata = r_host4;
        8'h08:   w_rdata = r_host8;
        default: w_rdata = '0;
      endcase
      for (int i = 0; i < NPARAM; i++) begin
        if (w_par_sel && w_idx == i[2:0]) w_rdata = r_host_par[i];
        if (w_rsp_sel && w_idx == i[2:0]) w_rdata = r_host_rsp[i];
      end
    end else if (w_tgt) begin
      case (w_off)
        8'h00:   w_rdata = r_tgt0;
        8'h04:   w_rdata = r_tgt4;
        8'h08:   w_rdata = r_tgt8;
        default: w_rdata = '0;
      endcase
      for (int i = 0; i < NPARAM; i++) begin
        if (w_par_sel && w_idx == i[2:0]) w_rdata = r_tgt_par[i];
        if (w_rsp_sel && w_idx == i[2:0]) w_rdata = r_tgt_rsp[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rd_data <= '0;
    else if (bus.bridge_rd)
      r_rd_data <= bus.bridge_endian_little ? swap32(w_rdata) : w_rdata;
  end

`ifdef BRIDGE_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hstate       <= H_IDLE;
      r_host0        <= '0;
      r_host4        <= 32'h20;
      r_host8        <= 32'h40;
      for (int i = 0; i < NPARAM; i++) begin
        r_host_par[i] <= '0;
        r_host_rsp[i] <= '0;
      end
      r_cmd          <= '0;
      r_code         <= '0;
      r_accepted     <= 1'b0;
      r_core_reset_n <= 1'b0;
      r_osnotify     <= 1'b0;
      r_hcmd_valid   <= 1'b0;
      r_hcmd_id      <= '0;
      r_hcmd_param   <= '0;
`ifdef BRIDGE_CMD_TIMEOUT_EN
      r_tmo          <= '0;
`endif
    end else begin
      if (bus.bridge_wr && w_host) begin
        case (w_off)
          8'h00:   if (r_hstate == H_IDLE) r_host0 <= w_wdata;
          8'h04:   r_host4 <= w_wdata;
          8'h08:   r_host8 <= w_wdata;
          default: ;
        endcase
        for (int i = 0; i < NPARAM; i++) begin
          if (w_par_sel && w_idx == i[2:0]) r_host_par[i] <= w_wdata;
          if (w_rsp_sel && w_idx == i[2:0]) r_host_rsp[i] <= w_wdata;
        end
      end

      case (r_hstate)
        H_IDLE: begin
          if (bus.bridge_wr && w_host && w_off == 8'h00 && w_wdata[31:16] == 16'h434D) begin
            r_cmd    <= w_wdata[15:0];
            r_hstate <= H_PARSE;
          end
        end
        H_PARSE: begin
          r_host0  <= {16'h4255, r_cmd};
          r_code   <= '0;
          r_hstate <= H_DONE;
          case (r_cmd)
            16'h0000: r_code <= {13'd0, w_status_code};
            16'h0010: r_core_reset_n <= 1'b0;
            16'h0011: r_core_reset_n <= 1'b1;
            16'h0080: r_code <= 16'h0001;
            16'h0082, 16'h008F: ;
            16'h00A0, 16'h00A4: for (int i = 0; i < NPARAM; i++) r_host_rsp[i] <= '0;
            16'h00B0: r_osnotify <= r_host_par[0][0];
            default: begin
              r_hcmd_valid <= 1'b1;
              r_hcmd_id    <= r_cmd;
              r_hcmd_param <= r_host_par[0];
              r_accepted   <= 1'b0;
              r_hstate     <= H_EXT;
`ifdef BRIDGE_CMD_TIMEOUT_EN
              r_tmo        <= TW'(TIMEOUT_CYCLES - 1);
`endif
            end
          endcase
        end
        H_EXT: begin
          if (r_hcmd_valid && bus.hcmd_ready) begin
            r_hcmd_valid <= 1'b0;
            r_accepted   <= 1'b1;
          end
          if (w_rsp_ok) begin
            r_code   <= bus.hcmd_rsp_code;
            r_hstate <= H_DONE;
          end
`ifdef BRIDGE_CMD_TIMEOUT_EN
          else if (r_tmo == '0) begin
            r_hcmd_valid <= 1'b0;
            r_code       <= 16'hFFFF;
            r_hstate     <= H_DONE;
          end else begin
            r_tmo <= r_tmo - 1'b1;
          end
`endif
        end
        H_DONE: begin
          r_host0  <= {16'h4F4B, r_code};
          r_hstate <= H_IDLE;
        end
        default: r_hstate <= H_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fq_cmd[r_wptr] <= bus.tq_cmd;
      r_fq_par[r_wptr] <= bus.tq_param;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tstate     <= T_IDLE;
      r_tgt0       <= '0;
      r_tgt4       <= 32'h20;
      r_tgt8       <= 32'h40;
      for (int i = 0; i < NPARAM; i++) begin
        r_tgt_par[i] <= '0;
        r_tgt_rsp[i] <= '0;
      end
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_setup_q    <= 1'b0;
      r_setup_pend <= 1'b0;
      r_tcmd       <= '0;
      r_tpar       <= '0;
      r_tq_done    <= 1'b0;
      r_tq_result  <= '0;
    end else begin
      r_setup_q <= bus.status_setup_done;
      r_tq_done <= 1'b0;
      if (r_tstate == T_IDLE && w_int_req) r_setup_pend <= 1'b0;
      else if (w_setup_rise)               r_setup_pend <= 1'b1;

      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase

      if (bus.bridge_wr && w_tgt) begin
        case (w_off)
          8'h00:   r_tgt0 <= w_wdata;
          8'h04:   r_tgt4 <= w_wdata;
          8'h08:   r_tgt8 <= w_wdata;
          default: ;
        endcase
        for (int i = 0; i < NPARAM; i++) begin
          if (w_par_sel && w_idx == i[2:0]) r_tgt_par[i] <= w_wdata;
          if (w_rsp_sel && w_idx == i[2:0]) r_tgt_rsp[i] <= w_wdata;
        end
      end

      case (r_tstate)
        T_IDLE: begin
          if (w_int_req) begin
            r_tcmd   <= 16'h0140;
            r_tpar   <= '0;
            r_tstate <= T_ISSUE;
          end else if (w_pop) begin
            r_tcmd   <= r_fq_cmd[r_rptr];
            r_tpar   <= r_fq_par[r_rptr];
            r_tstate <= T_ISSUE;
          end
        end
        T_ISSUE: begin
          r_tgt0       <= {16'h636D, r_tcmd};
          r_tgt_par[0] <= r_tpar;
          r_tstate     <= T_WAIT;
        end
        T_WAIT: begin
          if (r_tgt0[31:16] == 16'h6F6B) begin
            r_tq_result <= r_tgt0[15:0];
            r_tq_done   <= 1'b1;
            r_tstate    <= T_IDLE;
          end
        end
        default: r_tstate <= T_IDLE;
      endcase
    end
  end

  assign bus.bridge_rd_data  = r_rd_data;
  assign bus.core_reset_n    = r_core_reset_n;
  assign bus.osnotify_inmenu = r_osnotify;
  assign bus.hcmd_valid      = r_hcmd_valid;
  assign bus.hcmd_id         = r_hcmd_id;
  assign bus.hcmd_param      = r_hcmd_param;
  assign bus.tq_full         = w_full;
  assign bus.tq_done         = r_tq_done;
  assign bus.tq_result       = r_tq_result;

`ifdef BRIDGE_CMD_TIMEOUT_EN
  logic w_unused;
  assign w_unused = &{1'b0, bus.bridge_addr[23:16]};
`else
  logic w_unused;
  assign w_unused = &{1'b0, bus.bridge_addr[23:16], (TIMEOUT_CYCLES > 0)};
`endif
endmodule

// File: tb/tb_bridge_cmd_engine.sv
// Scoreboard bench for bridge_cmd_engine: stimulus queues expected reads, handshakes
// and target acks; a monitor compares them as the DUT presents each output.
module tb_bridge_cmd_engine;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bridge_cmd_engine_if bif();
  bridge_cmd_engine #(.NPARAM(4), .TQ_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bif)
  );

  localparam logic [31:0] H0 = 32'hF800_0000;
  localparam logic [31:0] T0 = 32'hF800_1000;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] q_rd[$];
  string       q_rdn[$];
  logic [15:0] q_hid[$];
  logic [31:0] q_hpar[$];
  logic [15:0] q_tq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // monitor: sample handshake inputs just before the edge, outputs just after it
  initial begin
    logic        rd_seen, hs_seen;
    logic [15:0] hs_id;
    logic [31:0] hs_par;
    forever begin
      @(negedge clk);
      #4;
      rd_seen = bif.bridge_rd && reset_n;
      hs_seen = bif.hcmd_valid && bif.hcmd_ready;
      hs_id   = bif.hcmd_id;
      hs_par  = bif.hcmd_param;
      @(posedge clk);
      #1;
      if (rd_seen) begin
        if (q_rd.size() == 0) check("unexpected_read", bif.bridge_rd_data, 32'hxxxx_xxxx);
        else check(q_rdn.pop_front(), bif.bridge_rd_data, q_rd.pop_front());
      end
      if (hs_seen) begin
        if (q_hid.size() == 0) check("unexpected_hcmd", 32'(hs_id), 32'hxxxx_xxxx);
        else begin
          check("hcmd_id", 32'(hs_id), 32'(q_hid.pop_front()));
          check("hcmd_param", hs_par, q_hpar.pop_front());
        end
      end
      if (bif.tq_done) begin
        if (q_tq.size() == 0) check("unexpected_tq_done", 32'(bif.tq_result), 32'hxxxx_xxxx);
        else check("tq_result", 32'(bif.tq_result), 32'(q_tq.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bif.bridge_addr = a; bif.bridge_wr_data = d; bif.bridge_wr = 1'b1;
    @(negedge clk);
    bif.bridge_wr = 1'b0;
  endtask

  task automatic bus_rd(input string n, input logic [31:0] a, input logic [31:0] e);
    @(negedge clk);
    bif.bridge_addr = a; bif.bridge_rd = 1'b1;
    q_rd.push_back(e); q_rdn.push_back(n);
    @(negedge clk);
    bif.bridge_rd = 1'b0;
  endtask

  task automatic host_cmd(input logic [15:0] c);
    bus_wr(H0, {16'h434D, c});
  endtask

  task automatic wait_hvalid();
    bit ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bif.hcmd_valid) begin ok = 1'b1; break; end
    end
    check("hcmd_valid_rise", 32'(ok), 32'd1);
  endtask

  task automatic tq_push(input logic [15:0] c, input logic [31:0] p);
    @(negedge clk);
    bif.tq_wr = 1'b1; bif.tq_cmd = c; bif.tq_param = p;
    @(negedge clk);
    bif.tq_wr = 1'b0;
  endtask

  task automatic tq_ack(input logic [15:0] r);
    q_tq.push_back(r);
    bus_wr(T0, {16'h6F6B, r});
  endtask

  initial begin
    bif.bridge_endian_little = 1'b0; bif.bridge_addr = '0; bif.bridge_rd = 1'b0;
    bif.bridge_wr = 1'b0; bif.bridge_wr_data = '0;
    bif.status_boot_done = 1'b0; bif.status_setup_done = 1'b0; bif.status_running = 1'b0;
    bif.hcmd_ready = 1'b0; bif.hcmd_rsp_valid = 1'b0; bif.hcmd_rsp_code = '0;
    bif.tq_wr = 1'b0; bif.tq_cmd = '0; bif.tq_param = '0;
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(1);

    check("rst_core_reset_n", 32'(bif.core_reset_n), 32'd0);
    check("rst_hcmd_valid", 32'(bif.hcmd_valid), 32'd0);
    check("rst_tq_full", 32'(bif.tq_full), 32'd0);
    check("rst_tq_done", 32'(bif.tq_done), 32'd0);
    check("rst_osnotify", 32'(bif.osnotify_inmenu), 32'd0);
    check("rst_rd_data", bif.bridge_rd_data, 32'd0);
    bus_rd("rst_host0", H0, 32'h0);
    bus_rd("rst_host4", H0 + 32'h4, 32'h20);
    bus_rd("rst_host8", H0 + 32'h8, 32'h40);
    bus_rd("rst_tgt0", T0, 32'h0);
    bus_rd("rst_tgt4", T0 + 32'h4, 32'h20);
    bus_rd("rst_tgt8", T0 + 32'h8, 32'h40);

    // decode boundaries: param index 4 is outside NPARAM=4, other windows unmapped
    bus_wr(H0 + 32'h30, 32'h55);
    bus_rd("out_of_nparam", H0 + 32'h30, 32'h0);
    bus_wr(H0 + 32'h2C, 32'h11);
    bus_rd("last_param", H0 + 32'h2C, 32'h11);
    bus_rd("other_window", 32'hF900_0004, 32'h0);
    bus_rd("unmapped_page", 32'hF800_2004, 32'h0);

    bif.status_boot_done = 1'b1; bif.status_running = 1'b1;
    host_cmd(16'h0000); wait_cyc(3);
    bus_rd("status_running", H0, 32'h4F4B_0004);
    bif.status_running = 1'b0;
    host_cmd(16'h0000); wait_cyc(3);
    bus_rd("status_setup", H0, 32'h4F4B_0002);

    host_cmd(16'h0011); wait_cyc(3);
    check("core_reset_n_hi", 32'(bif.core_reset_n), 32'd1);
    bus_rd("cmd0011", H0, 32'h4F4B_0000);
    host_cmd(16'h0010); wait_cyc(3);
    check("core_reset_n_lo", 32'(bif.core_reset_n), 32'd0);
    bus_rd("cmd0010", H0, 32'h4F4B_0000);
    host_cmd(16'h0080); wait_cyc(3);
    bus_rd("cmd0080", H0, 32'h4F4B_0001);

    // forwarded command, slow accept, separate response
    bus_wr(H0 + 32'h20, 32'hCAFE_F00D);
    q_hid.push_back(16'h1234); q_hpar.push_back(32'hCAFE_F00D);
    host_cmd(16'h1234);
    wait_hvalid();
    bus_rd("ext_busy", H0, 32'h4255_1234);
    host_cmd(16'h0011);
    @(negedge clk); bif.hcmd_ready = 1'b1;
    @(negedge clk); bif.hcmd_ready = 1'b0;
    check("hcmd_valid_drop", 32'(bif.hcmd_valid), 32'd0);
    wait_cyc(2);
    @(negedge clk); bif.hcmd_rsp_valid = 1'b1; bif.hcmd_rsp_code = 16'h0007;
    @(negedge clk); bif.hcmd_rsp_valid = 1'b0;
    wait_cyc(2);
    bus_rd("ext_result", H0, 32'h4F4B_0007);
    check("ext_busy_write_ignored", 32'(bif.core_reset_n), 32'd0);

    // response in the same cycle as the handshake
    q_hid.push_back(16'h2222); q_hpar.push_back(32'hCAFE_F00D);
    host_cmd(16'h2222);
    wait_hvalid();
    @(negedge clk);
    bif.hcmd_ready = 1'b1; bif.hcmd_rsp_valid = 1'b1; bif.hcmd_rsp_code = 16'h0009;
    @(negedge clk);
    bif.hcmd_ready = 1'b0; bif.hcmd_rsp_valid = 1'b0;
    wait_cyc(2);
    bus_rd("ext_same_cycle", H0, 32'h4F4B_0009);

    bus_wr(H0 + 32'h20, 32'h1);
    host_cmd(16'h00B0); wait_cyc(3);
    check("osnotify", 32'(bif.osnotify_inmenu), 32'd1);
    bus_rd("cmd00B0", H0, 32'h4F4B_0000);
    bus_wr(H0 + 32'h40, 32'hDEAD);
    bus_rd("rsp_word", H0 + 32'h40, 32'hDEAD);
    host_cmd(16'h00A0); wait_cyc(3);
    bus_rd("rsp_cleared", H0 + 32'h40, 32'h0);

    // little-endian bridge
    bif.bridge_endian_little = 1'b1; bif.status_running = 1'b1;
    bus_wr(H0, 32'h0000_4D43); wait_cyc(3);
    bus_rd("le_host0", H0, 32'h0400_4B4F);
    bus_wr(H0 + 32'h24, 32'h7856_3412);
    bus_rd("le_param_raw", H0 + 32'h24, 32'h7856_3412);
    bif.bridge_endian_little = 1'b0;
    bus_rd("le_param_be", H0 + 32'h24, 32'h1234_5678);

    // target queue: first command goes straight out, then overfill
    tq_push(16'h0101, 32'h1001); wait_cyc(4);
    bus_rd("tq_issue0", T0, 32'h636D_0101);
    bus_rd("tq_param0", T0 + 32'h20, 32'h1001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bif.tq_wr = 1'b1; bif.tq_cmd = 16'h0102 + 16'(i); bif.tq_param = 32'h1002 + 32'(i);
    end
    @(negedge clk); bif.tq_wr = 1'b0;
    check("tq_full", 32'(bif.tq_full), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tq_ack(16'h0003 + 16'(k));
      wait_cyc(4);
      if (k == 0) check("tq_not_full", 32'(bif.tq_full), 32'd0);
      if (k < 4) begin
        bus_rd("tq_next", T0, {16'h636D, 16'h0102 + 16'(k)});
        bus_rd("tq_next_param", T0 + 32'h20, 32'h1002 + 32'(k));
      end else begin
        bus_rd("tq_dropped", T0, 32'h6F6B_0007);
      end
    end
    check("tq_result_held", 32'(bif.tq_result), 32'h7);

    // setup_done rising edge beats a queued command
    tq_push(16'h0108, 32'h2008); wait_cyc(4);
    bus_rd("tq_issue8", T0, 32'h636D_0108);
    @(negedge clk);
    bif.tq_wr = 1'b1; bif.tq_cmd = 16'h0107; bif.tq_param = 32'h2007; bif.status_setup_done = 1'b1;
    @(negedge clk); bif.tq_wr = 1'b0;
    tq_ack(16'h0008); wait_cyc(4);
    bus_rd("int_cmd", T0, 32'h636D_0140);
    bus_rd("int_param", T0 + 32'h20, 32'h0);
    tq_ack(16'h0009); wait_cyc(4);
    bus_rd("after_int", T0, 32'h636D_0107);
    bus_rd("after_int_param", T0 + 32'h20, 32'h2007);
    tq_ack(16'h000A); wait_cyc(4);
    bus_rd("tq_idle", T0, 32'h6F6B_000A);

    // reset in the middle of both FSMs
    tq_push(16'h0109, 32'h0); wait_cyc(4);
    tq_push(16'h010A, 32'h0);
    host_cmd(16'h3333); wait_cyc(3);
    check("pre_reset_hvalid", 32'(bif.hcmd_valid), 32'd1);
    bif.status_setup_done = 1'b0;
    @(negedge clk); reset_n = 1'b0;
    wait_cyc(2);
    reset_n = 1'b1;
    wait_cyc(4);
    check("mid_rst_hvalid", 32'(bif.hcmd_valid), 32'd0);
    check("mid_rst_osnotify", 32'(bif.osnotify_inmenu), 32'd0);
    check("mid_rst_tq_full", 32'(bif.tq_full), 32'd0);
    check("mid_rst_tq_result", 32'(bif.tq_result), 32'd0);
    bus_rd("mid_rst_tgt0", T0, 32'h0);
    bus_rd("mid_rst_host0", H0, 32'h0);
    bus_rd("mid_rst_host20", H0 + 32'h20, 32'h0);

`ifdef BRIDGE_CMD_TIMEOUT_EN
    host_cmd(16'h5555); wait_cyc(24);
    bus_rd("timeout_code", H0, 32'h4F4B_FFFF);
    check("timeout_hvalid", 32'(bif.hcmd_valid), 32'd0);
    @(negedge clk); bif.hcmd_rsp_valid = 1'b1; bif.hcmd_rsp_code = 16'h0042;
    @(negedge clk); bif.hcmd_rsp_valid = 1'b0;
    wait_cyc(3);
    bus_rd("late_rsp_ignored", H0, 32'h4F4B_FFFF);
`endif

    wait_cyc(4);
    check("rd_queue_empty", 32'(q_rd.size()), 32'd0);
    check("hcmd_queue_empty", 32'(q_hid.size()), 32'd0);
    check("tq_queue_empty", 32'(q_tq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
